// File: rtl/mole_input_encoder_pkg.sv
// Game-wide constants and encodings shared by the mole input path.
package mole_input_encoder_pkg;

    localparam int NUM_MOLES               = 5;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int DEFAULT_CNT_W           = 18;
    localparam int CODE_W                  = 3;

    localparam logic [CODE_W-1:0] NO_HIT = 3'd0;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        REPORT       = 2'd1,
        WAIT_RELEASE = 2'd2
    } enc_state_t;

endpackage

// File: rtl/mole_input_encoder_key_debouncer.sv
// One mole button: 2-flop synchroniser, counting debouncer and press-edge detect.
module mole_input_encoder_key_debouncer
    import mole_input_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_raw_i,
    output logic stable_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             stable_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle where the synchronised level agrees with the accepted level restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= key_raw_i;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign press_o  = stable_q & ~stable_prev_q;

endmodule

// File: rtl/mole_input_encoder.sv
// Mole button front end: per-key debouncers feeding a lowest-index priority
// encoder and a one-report-per-press FSM that produces the hit code and strobe.
module mole_input_encoder
    import mole_input_encoder_pkg::*;
#(
    parameter int NUM_KEYS        = NUM_MOLES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic                game_active,
    output logic [CODE_W-1:0]   user_game_input,
    output logic                hit_valid,
    output logic [NUM_KEYS-1:0] keys_stable
);

    localparam int SEL_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic [NUM_KEYS-1:0] stable_w;
    logic [NUM_KEYS-1:0] press_w;
    logic                any_press;
    logic [SEL_W-1:0]    first_idx;

    enc_state_t          state_q;
    logic [SEL_W-1:0]    sel_q;
    logic [CODE_W-1:0]   code_q;
    logic                hit_q;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            mole_input_encoder_key_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_deb (
                .clk_i     (clock),
                .rst_ni    (reset),
                .key_raw_i (key_raw[gi]),
                .stable_o  (stable_w[gi]),
                .press_o   (press_w[gi])
            );
        end
    endgenerate

    // Scan from the top down so the lowest pressed index wins.
    always_comb begin
        any_press = |press_w;
        first_idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (press_w[k]) begin
                first_idx = SEL_W'(k);
            end
        end
    end

    // The hit outputs are loaded on the IDLE->REPORT edge so they are high
    // for exactly the cycle spent in REPORT.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            code_q  <= NO_HIT;
            hit_q   <= 1'b0;
        end else begin
            code_q <= NO_HIT;
            hit_q  <= 1'b0;
            if (!game_active) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (any_press) begin
                            sel_q   <= first_idx;
                            code_q  <= CODE_W'(first_idx) + CODE_W'(1);
                            hit_q   <= 1'b1;
                            state_q <= REPORT;
                        end
                    end
                    REPORT: begin
                        state_q <= WAIT_RELEASE;
                    end
                    WAIT_RELEASE: begin
                        if (!stable_w[sel_q]) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign user_game_input = code_q;
    assign hit_valid       = hit_q;
    assign keys_stable     = stable_w;

endmodule

// File: tb/tb_mole_input_encoder.sv
// Self-checking bench for mole_input_encoder with a short debounce window.
module tb_mole_input_encoder;

    localparam int NK  = 5;
    localparam int DEB = 4;

    logic          clk;
    logic          rst_n;
    logic [NK-1:0] raw;
    logic          ga;
    logic [2:0]    code;
    logic          hit;
    logic [NK-1:0] stable;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    mole_input_encoder #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3)
    ) dut (
        .clock           (clk),
        .reset           (rst_n),
        .key_raw         (raw),
        .game_active     (ga),
        .user_game_input (code),
        .hit_valid       (hit),
        .keys_stable     (stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a key's accepted level flips once the last DEB
    // synchronised samples all disagree with it; the reporter owns one key
    // from its report until that key's accepted level drops.
    logic [NK-1:0] m_syncq[$];
    logic [NK-1:0] m_last_raw;
    logic [NK-1:0] m_stable;
    logic [NK-1:0] m_prev;
    int            m_owner;
    bit            m_just;
    logic [2:0]    m_code;
    logic          m_hit;

    task automatic model_edge(input logic r, input logic g, input logic [NK-1:0] kr);
        logic [NK-1:0] press;
        logic [NK-1:0] nstab;
        bit            all_diff;
        if (!r) begin
            m_syncq = {};
            for (int i = 0; i < DEB; i++) m_syncq.push_back('0);
            m_last_raw = '0;
            m_stable   = '0;
            m_prev     = '0;
            m_owner    = -1;
            m_just     = 0;
            m_code     = 3'd0;
            m_hit      = 1'b0;
        end else begin
            press  = m_stable & ~m_prev;
            m_code = 3'd0;
            m_hit  = 1'b0;
            if (!g) begin
                m_owner = -1;
                m_just  = 0;
            end else if (m_just) begin
                m_just = 0;
            end else if (m_owner >= 0) begin
                if (!m_stable[m_owner]) m_owner = -1;
            end else if (press != '0) begin
                for (int k = NK - 1; k >= 0; k--) if (press[k]) m_owner = k;
                m_code = 3'(m_owner + 1);
                m_hit  = 1'b1;
                m_just = 1;
            end
            nstab = m_stable;
            for (int k = 0; k < NK; k++) begin
                all_diff = 1;
                for (int i = 0; i < DEB; i++)
                    if (m_syncq[m_syncq.size() - 1 - i][k] == m_stable[k]) all_diff = 0;
                if (all_diff) nstab[k] = ~m_stable[k];
            end
            m_prev   = m_stable;
            m_stable = nstab;
            m_syncq.push_back(m_last_raw);
            if (m_syncq.size() > DEB) void'(m_syncq.pop_front());
            m_last_raw = kr;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // One clock: capture the inputs the edge sees, advance the model, compare.
    task automatic step();
        logic          r;
        logic          g;
        logic [NK-1:0] kr;
        r  = rst_n;
        g  = ga;
        kr = raw;
        @(posedge clk);
        #1;
        cycle++;
        model_edge(r, g, kr);
        chk("model_code", 32'(code), 32'(m_code));
        chk("model_hit", 32'(hit), 32'(m_hit));
        chk("model_stable", 32'(stable), 32'(m_stable));
        if (hit) $display("cycle %0d: hit code %0d keys_stable %b", cycle, code, stable);
    endtask

    task automatic run(input int n, output int first_edge, output int hits, output logic [2:0] first_code);
        first_edge = -1;
        hits       = 0;
        first_code = 3'd0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (hit) begin
                hits++;
                if (first_edge < 0) begin
                    first_edge = i;
                    first_code = code;
                end
            end
        end
    endtask

    typedef struct {
        logic          rst;
        logic          ga;
        logic [NK-1:0] raw;
        logic [2:0]    code;
        logic          hit;
        logic [NK-1:0] stable;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int         fe;
        int         nh;
        int         acc;
        logic [2:0] fc;

        rst_n = 1'b0;
        ga    = 1'b1;
        raw   = '0;

        // Table: reset, clean press of key 0, debounced release.
        tbl[0] = '{1'b0, 1'b1, 5'b00000, 3'd0, 1'b0, 5'b00000};
        tbl[1] = '{1'b0, 1'b1, 5'b00001, 3'd0, 1'b0, 5'b00000};
        for (int i = 2; i <= 6; i++) tbl[i] = '{1'b1, 1'b1, 5'b00001, 3'd0, 1'b0, 5'b00000};
        tbl[7] = '{1'b1, 1'b1, 5'b00001, 3'd0, 1'b0, 5'b00001};
        tbl[8] = '{1'b1, 1'b1, 5'b00001, 3'd1, 1'b1, 5'b00001};
        tbl[9] = '{1'b1, 1'b1, 5'b00001, 3'd0, 1'b0, 5'b00001};
        for (int i = 10; i <= 14; i++) tbl[i] = '{1'b1, 1'b1, 5'b00000, 3'd0, 1'b0, 5'b00001};
        for (int i = 15; i <= 17; i++) tbl[i] = '{1'b1, 1'b1, 5'b00000, 3'd0, 1'b0, 5'b00000};
        for (int i = 0; i < 18; i++) begin
            rst_n = tbl[i].rst;
            ga    = tbl[i].ga;
            raw   = tbl[i].raw;
            step();
            chk($sformatf("tbl%0d_code", i), 32'(code), 32'(tbl[i].code));
            chk($sformatf("tbl%0d_hit", i), 32'(hit), 32'(tbl[i].hit));
            chk($sformatf("tbl%0d_stable", i), 32'(stable), 32'(tbl[i].stable));
        end

        // Reset held with all keys down, then release with game inactive.
        ga    = 1'b0;
        raw   = 5'b11111;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_code", 32'(code), 32'd0);
            chk("rst_hit", 32'(hit), 32'd0);
            chk("rst_stable", 32'(stable), 32'd0);
        end
        rst_n = 1'b1;
        acc = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (hit) acc++;
            if (i == 5) chk("rst_stable_e5", 32'(stable), 32'd0);
            if (i == 6) chk("rst_stable_e6", 32'(stable), 32'h1f);
        end
        chk("rst_no_hit", 32'(acc), 32'd0);

        // Clean press of key 2.
        raw = '0;
        run(12, fe, nh, fc);
        ga = 1'b1;
        run(2, fe, nh, fc);
        raw = 5'b00100;
        run(12, fe, nh, fc);
        chk("clean_edge", 32'(fe), 32'd7);
        chk("clean_code", 32'(fc), 32'd3);
        chk("clean_hits", 32'(nh), 32'd1);

        // Bouncing press of key 0, then glitchy release.
        raw = '0;
        run(12, fe, nh, fc);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            raw[0] = (i % 2 == 0);
            run(1, fe, nh, fc);
            acc += nh;
        end
        raw[0] = 1'b1;
        run(12, fe, nh, fc);
        chk("bounce_edge", 32'(fe), 32'd7);
        chk("bounce_code", 32'(fc), 32'd1);
        chk("bounce_hits", 32'(nh + acc), 32'd1);
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            raw[0] = (i % 4) >= 2;
            run(1, fe, nh, fc);
            acc += nh;
        end
        raw[0] = 1'b0;
        run(20, fe, nh, fc);
        chk("glitch_release_hits", 32'(nh + acc), 32'd0);

        // Simultaneous presses of keys 1 and 4.
        raw = 5'b10010;
        run(12, fe, nh, fc);
        chk("simul_code", 32'(fc), 32'd2);
        chk("simul_hits", 32'(nh), 32'd1);
        raw = 5'b10000;
        run(20, fe, nh, fc);
        chk("simul_key4_hits", 32'(nh), 32'd0);
        raw = '0;
        run(12, fe, nh, fc);

        // Key held across game start, then re-pressed.
        ga  = 1'b0;
        raw = 5'b01000;
        run(10, fe, nh, fc);
        ga = 1'b1;
        run(10, fe, nh, fc);
        chk("held_start_hits", 32'(nh), 32'd0);
        raw = '0;
        run(7, fe, nh, fc);
        raw = 5'b01000;
        run(12, fe, nh, fc);
        chk("repress_edge", 32'(fe), 32'd7);
        chk("repress_code", 32'(fc), 32'd4);

        // Reset mid-count.
        raw = '0;
        run(12, fe, nh, fc);
        raw = 5'b00010;
        run(3, fe, nh, fc);
        acc = nh;
        rst_n = 1'b0;
        step();
        chk("midrst_stable", 32'(stable), 32'd0);
        chk("midrst_hit", 32'(hit), 32'd0);
        rst_n = 1'b1;
        run(12, fe, nh, fc);
        chk("midrst_pre_hits", 32'(acc), 32'd0);
        chk("midrst_edge", 32'(fe), 32'd7);
        chk("midrst_code", 32'(fc), 32'd2);

        // Random traffic against the model.
        raw = '0;
        ga  = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            int k;
            k = $urandom_range(0, NK - 1);
            if ($urandom_range(0, 15) == 0) raw[k] = ~raw[k];
            if ($urandom_range(0, 199) == 0) ga = ~ga;
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
